ahb_ssram_bridge: RTL

AHB-Lite slave that converts bus transfers into single-port synchronous SRAM accesses. It drives a 32-bit write-first sync RAM (en/we/addr/din in, dout out one cycle later) and sits directly upstream of that RAM inside the AHB-to-SSRAM subsystem. It provides zero-wait-state reads and full-word writes, byte and halfword writes by read-modify-write, one-wait-state port-conflict arbitration, and a two-cycle ERROR response for illegal transfers.

---
 rtl/ahb_ssram_bridge_if.sv | 25 ++
 rtl/ahb_ssram_bridge.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ahb_ssram_bridge_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the SSRAM bridge.
// Carries address/control, write data, bus-level hready and the slave response.
// Modports: master drives the request side, slave drives hreadyout/hresp/hrdata.
interface ahb_ssram_bridge_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_ssram_bridge.sv
// AHB-Lite slave to single-port 32-bit write-first sync SRAM bridge.
// Latency: reads return data the cycle after the address phase (one wait state
// when queued behind a write); writes commit at the edge ending the data phase;
// subword writes are read-modify-write; illegal transfers get a 2-cycle ERROR.
// Ports: clk, rst (async, active-high), ahb (slave modport of the AHB bundle),
// ram_en/ram_we/ram_addr/ram_din towards the RAM, ram_dout back from it.
module ahb_ssram_bridge #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  ahb_ssram_bridge_if.slave     ahb,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_STALL = 3'd3,
    S_ERR1  = 3'd4,
    S_ERR2  = 3'd5
  } state_t;

  state_t                state, state_nxt;

  // Data-phase registers captured on an accepted transfer
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lane_q;
  logic [1:0]            size_q;
  logic                  write_q;

  logic                  ready_int;
  logic                  accept;
  logic                  legal;
  logic                  need_port;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [3:0]            be;
  logic [31:0]           merged;

  // Upper address bits alias; htrans[0] only distinguishes NONSEQ from SEQ
  logic                  unused_bits;
  assign unused_bits = ^{ahb.haddr[31:ADDR_WIDTH+2], ahb.htrans[0]};

  assign haddr_word = ahb.haddr[ADDR_WIDTH+1:2];
  assign ready_int  = (state != S_STALL) && (state != S_ERR1);
  assign accept     = ahb.hsel && ahb.hready && ahb.htrans[1] && ready_int;

  assign legal = (ahb.hsize <= 3'd2)
              && !((ahb.hsize == 3'd1) && ahb.haddr[0])
              && !((ahb.hsize == 3'd2) && (ahb.haddr[1:0] != 2'b00));

  // Reads and subword writes (pre-read) use the RAM port in the address phase
  assign need_port = legal && (!ahb.hwrite || (ahb.hsize != 3'd2));

  // Little-endian lane enables for the pending write
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << lane_q;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    merged = ram_dout;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = ahb.hwdata[8*i +: 8];
    end
  end

  // State register and data-phase capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= haddr_word;
        lane_q  <= ahb.haddr[1:0];
        size_q  <= ahb.hsize[1:0];
        write_q <= ahb.hwrite;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_STALL: state_nxt = write_q ? S_WR : S_RD;
      S_ERR1:  state_nxt = S_ERR2;
      default: begin
        if (accept) begin
          if (!legal)
            state_nxt = S_ERR1;
          else if ((state == S_WR) && need_port)
            state_nxt = S_STALL;      // port is busy with the current write
          else
            state_nxt = ahb.hwrite ? S_WR : S_RD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    ahb.hreadyout = ready_int;
    ahb.hresp     = (state == S_ERR1) || (state == S_ERR2);
    ahb.hrdata    = (state == S_RD) ? ram_dout : 32'h0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_din       = 32'h0;
    if (!rst) begin
      case (state)
        S_WR: begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = addr_q;
          ram_din  = merged;
        end
        S_STALL: begin
          ram_en   = 1'b1;
          ram_addr = addr_q;
        end
        default: begin
          // Address-phase read straight from the bus when the port is free
          if (accept && need_port) begin
            ram_en   = 1'b1;
            ram_addr = haddr_word;
          end
        end
      endcase
    end
  end

endmodule
